// File: rtl/fsm_movement.sv
// rtl/fsm_movement.sv - player movement control FSM for the Zork datapath
//
// Purpose: captures a key press, requests key validation, then move validation,
// fires one position-adder enable, waits for its acknowledge, then pulses the
// move counter.
//
// Ports:
//   clk_50MHz_i            system clock, rising edge
//   rst_async_la_i         asynchronous active-low reset
//   key_in                 key code from the keyboard front end
//   last_key_in            key strobe; a 0->1 transition is a new press
//   valid_key              key validator result (1 = legal movement key)
//   valid_move             move validator status: [1] ready, [0] legal
//   movement_direction     1 = movement key (proceed), 0 = abort
//   moved                  adder acknowledge
//   enable_save_last       force-load last_pressed from key_in
//   enable_sum_PX/NX/PY/NY one-cycle adder enables
//   enable_validation_key  high while waiting on the key validator
//   enable_validation_move high while waiting on the move validator
//   enable_count_move      one-cycle move counter pulse
//   last_pressed           captured key code

module fsm_movement #(
  parameter int KEY_W = 4
) (
  input  logic             clk_50MHz_i,
  input  logic             rst_async_la_i,
  input  logic [KEY_W-1:0] key_in,
  input  logic             last_key_in,
  input  logic             valid_key,
  input  logic [1:0]       valid_move,
  input  logic             movement_direction,
  input  logic             moved,
  input  logic             enable_save_last,
  output logic             enable_sum_PX,
  output logic             enable_sum_NX,
  output logic             enable_sum_PY,
  output logic             enable_sum_NY,
  output logic             enable_validation_key,
  output logic             enable_validation_move,
  output logic             enable_count_move,
  output logic [KEY_W-1:0] last_pressed
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VAL_KEY  = 3'd1,
    VAL_MOVE = 3'd2,
    EXEC     = 3'd3,
    WAIT_ACK = 3'd4,
    COUNT    = 3'd5
  } state_t;

  state_t           state;
  logic             last_key_q;
  logic             rise;
  logic             load_key;
  logic [KEY_W-1:0] key_nxt;

  assign rise = last_key_in & ~last_key_q;

  // Capture happens on a fresh press in IDLE, a restart press in VAL_KEY,
  // or a forced save. All sources load the same key_in.
  assign load_key = enable_save_last |
                    (rise & ((state == IDLE) | (state == VAL_KEY)));

  // The direction decode for EXEC must see a save that lands on the same
  // cycle as the VAL_MOVE -> EXEC transition.
  assign key_nxt = load_key ? key_in : last_pressed;

  // Outputs are registered alongside the state so they track the state
  // register exactly (Moore behaviour without a decode stage).
  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state                  <= IDLE;
      last_key_q             <= 1'b0;
      last_pressed           <= '0;
      enable_sum_PX          <= 1'b0;
      enable_sum_NX          <= 1'b0;
      enable_sum_PY          <= 1'b0;
      enable_sum_NY          <= 1'b0;
      enable_validation_key  <= 1'b0;
      enable_validation_move <= 1'b0;
      enable_count_move      <= 1'b0;
    end else begin
      last_key_q <= last_key_in;
      if (load_key) begin
        last_pressed <= key_in;
      end

      enable_sum_PX          <= 1'b0;
      enable_sum_NX          <= 1'b0;
      enable_sum_PY          <= 1'b0;
      enable_sum_NY          <= 1'b0;
      enable_validation_key  <= 1'b0;
      enable_validation_move <= 1'b0;
      enable_count_move      <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state                 <= VAL_KEY;
            enable_validation_key <= 1'b1;
          end
        end

        VAL_KEY: begin
          // A new press restarts capture and takes priority over a verdict
          // that belongs to the previous key.
          if (rise) begin
            state                 <= VAL_KEY;
            enable_validation_key <= 1'b1;
          end else if (valid_key && movement_direction) begin
            state                  <= VAL_MOVE;
            enable_validation_move <= 1'b1;
          end else if (valid_key) begin
            state <= IDLE;
          end else begin
            enable_validation_key <= 1'b1;
          end
        end

        VAL_MOVE: begin
          if (valid_move == 2'b11) begin
            state <= EXEC;
            case (key_nxt[1:0])
              2'b10:   enable_sum_PX <= 1'b1;
              2'b11:   enable_sum_NX <= 1'b1;
              2'b00:   enable_sum_PY <= 1'b1;
              default: enable_sum_NY <= 1'b1;
            endcase
          end else if (valid_move[1]) begin
            state <= IDLE;
          end else begin
            enable_validation_move <= 1'b1;
          end
        end

        EXEC: begin
          state <= WAIT_ACK;
        end

        WAIT_ACK: begin
          if (moved) begin
            state             <= COUNT;
            enable_count_move <= 1'b1;
          end
        end

        COUNT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_movement.sv
// tb/tb_fsm_movement.sv - scoreboard testbench for fsm_movement

module tb_fsm_movement;

  localparam logic [6:0] E_PX = 7'b1000000;
  localparam logic [6:0] E_NX = 7'b0100000;
  localparam logic [6:0] E_PY = 7'b0010000;
  localparam logic [6:0] E_NY = 7'b0001000;
  localparam logic [6:0] E_VK = 7'b0000100;
  localparam logic [6:0] E_VM = 7'b0000010;
  localparam logic [6:0] E_CM = 7'b0000001;

  typedef struct packed {
    logic [6:0] en;
    logic [3:0] lp;
  } exp_t;

  logic       clk_50MHz_i = 1'b0;
  logic       rst_async_la_i = 1'b0;
  logic [3:0] key_in = 4'd0;
  logic       last_key_in = 1'b0;
  logic       valid_key = 1'b1;
  logic [1:0] valid_move = 2'b11;
  logic       movement_direction = 1'b1;
  logic       moved = 1'b1;
  logic       enable_save_last = 1'b0;
  logic       enable_sum_PX, enable_sum_NX, enable_sum_PY, enable_sum_NY;
  logic       enable_validation_key, enable_validation_move, enable_count_move;
  logic [3:0] last_pressed;

  logic [6:0] en_vec;
  assign en_vec = {enable_sum_PX, enable_sum_NX, enable_sum_PY, enable_sum_NY,
                   enable_validation_key, enable_validation_move, enable_count_move};

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  fsm_movement #(.KEY_W(4)) dut (
    .clk_50MHz_i            (clk_50MHz_i),
    .rst_async_la_i         (rst_async_la_i),
    .key_in                 (key_in),
    .last_key_in            (last_key_in),
    .valid_key              (valid_key),
    .valid_move             (valid_move),
    .movement_direction     (movement_direction),
    .moved                  (moved),
    .enable_save_last       (enable_save_last),
    .enable_sum_PX          (enable_sum_PX),
    .enable_sum_NX          (enable_sum_NX),
    .enable_sum_PY          (enable_sum_PY),
    .enable_sum_NY          (enable_sum_NY),
    .enable_validation_key  (enable_validation_key),
    .enable_validation_move (enable_validation_move),
    .enable_count_move      (enable_count_move),
    .last_pressed           (last_pressed)
  );

  always #5 clk_50MHz_i = ~clk_50MHz_i;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_50MHz_i);
    #1;
  endtask

  task automatic push(input logic [6:0] en, input logic [3:0] lp);
    exp_t e;
    e.en = en;
    e.lp = lp;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle with any enable high consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50MHz_i);
      if (|en_vec) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: actual en=%b lp=%b required none", en_vec, last_pressed);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", {en_vec, last_pressed}, {e.en, e.lp});
        end
      end
    end
  end

  task automatic run_happy(input logic [3:0] k, input logic [6:0] sum);
    key_in = k;
    push(E_VK, k);
    push(E_VM, k);
    push(sum, k);
    push(E_CM, k);
    last_key_in = 1'b1;
    repeat (3) tick();
    last_key_in = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #2;
    check("reset_enables", {4'd0, en_vec}, 11'd0);
    check("reset_last_pressed", {7'd0, last_pressed}, 11'd0);
    #10;
    rst_async_la_i = 1'b1;
    repeat (3) tick();

    run_happy(4'b1010, E_PX);
    check("happy_last_pressed", {7'd0, last_pressed}, {7'd0, 4'b1010});
    run_happy(4'b0011, E_NX);
    run_happy(4'b0100, E_PY);
    run_happy(4'b0101, E_NY);

    // Key rejected as non-movement
    key_in = 4'b0010;
    movement_direction = 1'b0;
    push(E_VK, 4'b0010);
    last_key_in = 1'b1;
    repeat (3) tick();
    last_key_in = 1'b0;
    repeat (5) tick();
    movement_direction = 1'b1;

    // Illegal move
    key_in = 4'b0110;
    valid_move = 2'b10;
    push(E_VK, 4'b0110);
    push(E_VM, 4'b0110);
    last_key_in = 1'b1;
    repeat (3) tick();
    last_key_in = 1'b0;
    repeat (5) tick();
    valid_move = 2'b11;

    // Stalls in VAL_KEY and WAIT_ACK, ignored strobe in WAIT_ACK
    valid_key = 1'b0;
    moved = 1'b0;
    key_in = 4'b0011;
    last_key_in = 1'b1;
    push(E_VK, 4'b0011);
    tick();
    last_key_in = 1'b0;
    repeat (5) begin
      push(E_VK, 4'b0011);
      tick();
    end
    valid_key = 1'b1;
    push(E_VM, 4'b0011);
    tick();
    push(E_NX, 4'b0011);
    tick();
    tick();
    key_in = 4'b1111;
    last_key_in = 1'b1;
    tick();
    tick();
    last_key_in = 1'b0;
    check("wait_ack_strobe_ignored", {7'd0, last_pressed}, {7'd0, 4'b0011});
    tick();
    tick();
    moved = 1'b1;
    push(E_CM, 4'b0011);
    tick();
    repeat (4) tick();

    // Forced save during VAL_MOVE redirects the move
    key_in = 4'b0101;
    valid_move = 2'b00;
    push(E_VK, 4'b0101);
    push(E_VM, 4'b0101);
    push(E_VM, 4'b0110);
    push(E_PX, 4'b0110);
    push(E_CM, 4'b0110);
    last_key_in = 1'b1;
    tick();
    last_key_in = 1'b0;
    tick();
    enable_save_last = 1'b1;
    key_in = 4'b0110;
    tick();
    enable_save_last = 1'b0;
    key_in = 4'b0001;
    valid_move = 2'b11;
    repeat (6) tick();
    check("save_last_value", {7'd0, last_pressed}, {7'd0, 4'b0110});

    // Reset asserted while EXEC enable is up
    key_in = 4'b1010;
    push(E_VK, 4'b1010);
    push(E_VM, 4'b1010);
    last_key_in = 1'b1;
    repeat (3) tick();
    rst_async_la_i = 1'b0;
    #1;
    check("reset_mid_exec_enables", {4'd0, en_vec}, 11'd0);
    check("reset_mid_exec_last_pressed", {7'd0, last_pressed}, 11'd0);
    last_key_in = 1'b0;
    repeat (2) tick();
    #2;
    rst_async_la_i = 1'b1;
    repeat (8) tick();
    check("after_reset_idle", {4'd0, en_vec}, 11'd0);

    check("queue_drained", 11'(exp_q.size()), 11'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
